// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU. It decodes the ALU control code
// when an instruction loads and forwards the operands from the EX/MEM and MEM/WB stages.
`default_nettype none

module id_ex_stage #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_aluop,
  input  logic [5:0]    in_funct,
  input  logic [DW-1:0] in_rs_data,
  input  logic [DW-1:0] in_rt_data,
  input  logic [DW-1:0] in_imm,
  input  logic          in_alusrc,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_dst,
  input  logic          in_regwrite,
  input  logic          in_memread,
  input  logic          in_memwrite,
  input  logic          in_memtoreg,
  input  logic          exm_regwrite,
  input  logic [AW-1:0] exm_dst,
  input  logic [DW-1:0] exm_data,
  input  logic          mwb_regwrite,
  input  logic [AW-1:0] mwb_dst,
  input  logic [DW-1:0] mwb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    alu_control,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] store_data,
  output logic [AW-1:0] out_dst,
  output logic          out_regwrite,
  output logic          out_memread,
  output logic          out_memwrite,
  output logic          out_memtoreg,
  output logic          out_illegal,
  output logic [CW-1:0] stall_count
);

  logic [DW-1:0] held_rs_data, held_rt_data, held_imm;
  logic [AW-1:0] held_rs, held_rt;
  logic          held_alusrc;
  logic [3:0]    ctl_dec;
  logic          illegal_dec;
  logic          load;
  logic [DW-1:0] fwd_rs, fwd_rt;

  assign in_ready = !out_valid | out_ready | flush;
  assign load     = in_valid & in_ready & !flush;

  always_comb begin
    ctl_dec     = 4'b0010;
    illegal_dec = 1'b0;
    case (in_aluop)
      2'b00: ctl_dec = 4'b0010;
      2'b01: ctl_dec = 4'b0110;
      2'b11: ctl_dec = 4'b0001;
      default: begin
        case (in_funct)
          6'b100000, 6'b100001: ctl_dec = 4'b0010;
          6'b100010, 6'b100011: ctl_dec = 4'b0110;
          6'b100100:            ctl_dec = 4'b0000;
          6'b100101:            ctl_dec = 4'b0001;
          6'b100111:            ctl_dec = 4'b1100;
          6'b101010:            ctl_dec = 4'b0111;
          default: begin
            ctl_dec     = 4'b0010;
            illegal_dec = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      alu_control  <= 4'b0000;
      held_rs_data <= '0;
      held_rt_data <= '0;
      held_imm     <= '0;
      held_rs      <= '0;
      held_rt      <= '0;
      held_alusrc  <= 1'b0;
      out_dst      <= '0;
      out_regwrite <= 1'b0;
      out_memread  <= 1'b0;
      out_memwrite <= 1'b0;
      out_memtoreg <= 1'b0;
      out_illegal  <= 1'b0;
      stall_count  <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_count))
        stall_count <= stall_count + CW'(1);
      if (flush) begin
        // Squash only the strobes that cause side effects; data is don't-care once invalid.
        out_valid    <= 1'b0;
        out_regwrite <= 1'b0;
        out_memread  <= 1'b0;
        out_memwrite <= 1'b0;
      end else if (load) begin
        out_valid    <= 1'b1;
        alu_control  <= ctl_dec;
        held_rs_data <= in_rs_data;
        held_rt_data <= in_rt_data;
        held_imm     <= in_imm;
        held_rs      <= in_rs;
        held_rt      <= in_rt;
        held_alusrc  <= in_alusrc;
        out_dst      <= in_dst;
        out_regwrite <= in_regwrite & !illegal_dec;
        out_memread  <= in_memread;
        out_memwrite <= in_memwrite & !illegal_dec;
        out_memtoreg <= in_memtoreg;
        out_illegal  <= illegal_dec;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // EX/MEM is applied last so that it takes priority over MEM/WB.
  always_comb begin
    fwd_rs = held_rs_data;
    fwd_rt = held_rt_data;
    if (mwb_regwrite && (mwb_dst != '0) && (mwb_dst == held_rs)) fwd_rs = mwb_data;
    if (exm_regwrite && (exm_dst != '0) && (exm_dst == held_rs)) fwd_rs = exm_data;
    if (mwb_regwrite && (mwb_dst != '0) && (mwb_dst == held_rt)) fwd_rt = mwb_data;
    if (exm_regwrite && (exm_dst != '0) && (exm_dst == held_rt)) fwd_rt = exm_data;
  end

  assign alu_a      = fwd_rs;
  assign store_data = fwd_rt;
  assign alu_b      = held_alusrc ? held_imm : fwd_rt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage; stall counter narrowed to 4 bits so saturation is reachable.
`default_nettype none

module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready;
  logic [1:0] in_aluop = '0;
  logic [5:0] in_funct = '0;
  logic [DW-1:0] in_rs_data = '0, in_rt_data = '0, in_imm = '0;
  logic in_alusrc = 1'b0;
  logic [AW-1:0] in_rs = '0, in_rt = '0, in_dst = '0;
  logic in_regwrite = 1'b0, in_memread = 1'b0, in_memwrite = 1'b0, in_memtoreg = 1'b0;
  logic exm_regwrite = 1'b0, mwb_regwrite = 1'b0;
  logic [AW-1:0] exm_dst = '0, mwb_dst = '0;
  logic [DW-1:0] exm_data = '0, mwb_data = '0;
  logic out_valid, out_ready = 1'b1;
  logic [3:0] alu_control;
  logic [DW-1:0] alu_a, alu_b, store_data;
  logic [AW-1:0] out_dst;
  logic out_regwrite, out_memread, out_memwrite, out_memtoreg, out_illegal;
  logic [CW-1:0] stall_count;

  id_ex_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_funct(in_funct), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_alusrc(in_alusrc), .in_rs(in_rs), .in_rt(in_rt), .in_dst(in_dst),
    .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_memtoreg(in_memtoreg), .exm_regwrite(exm_regwrite), .exm_dst(exm_dst),
    .exm_data(exm_data), .mwb_regwrite(mwb_regwrite), .mwb_dst(mwb_dst), .mwb_data(mwb_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control), .alu_a(alu_a),
    .alu_b(alu_b), .store_data(store_data), .out_dst(out_dst), .out_regwrite(out_regwrite),
    .out_memread(out_memread), .out_memwrite(out_memwrite), .out_memtoreg(out_memtoreg),
    .out_illegal(out_illegal), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    ctl;
    logic [DW-1:0] a, b, sd;
    logic [AW-1:0] dst;
    logic          rw, mw, ill;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [DW-1:0] rsd, rtd, imm, input logic src,
                                 input logic [AW-1:0] dst, input logic rw, mw);
    exp_t e;
    e.ill = 1'b0;
    e.ctl = 4'b0010;
    if (op == 2'b01) e.ctl = 4'b0110;
    else if (op == 2'b11) e.ctl = 4'b0001;
    else if (op == 2'b10) begin
      case (fn)
        6'h20, 6'h21: e.ctl = 4'b0010;
        6'h22, 6'h23: e.ctl = 4'b0110;
        6'h24:        e.ctl = 4'b0000;
        6'h25:        e.ctl = 4'b0001;
        6'h27:        e.ctl = 4'b1100;
        6'h2a:        e.ctl = 4'b0111;
        default:      e.ill = 1'b1;
      endcase
    end
    e.a   = rsd;
    e.b   = src ? imm : rtd;
    e.sd  = rtd;
    e.dst = dst;
    e.rw  = rw & !e.ill;
    e.mw  = mw & !e.ill;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.ctl = alu_control; o.a = alu_a; o.b = alu_b; o.sd = store_data; o.dst = out_dst;
    o.rw = out_regwrite; o.mw = out_memwrite; o.ill = out_illegal;
    return o;
  endfunction

  task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                       input logic [DW-1:0] rsd, rtd, imm, input logic src,
                       input logic [AW-1:0] rs, rt, dst, input logic rw, mr, mw, input bit push);
    in_valid = 1'b1; in_aluop = op; in_funct = fn; in_rs_data = rsd; in_rt_data = rtd;
    in_imm = imm; in_alusrc = src; in_rs = rs; in_rt = rt; in_dst = dst;
    in_regwrite = rw; in_memread = mr; in_memwrite = mw; in_memtoreg = mr;
    if (push) sb.push_back(model(op, fn, rsd, rtd, imm, src, dst, rw, mw));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || alu_control !== 4'b0000 || stall_count !== '0 || out_regwrite !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: valid=%b ctl=%b stall=%0d rw=%b want 0/0000/0/0", out_valid, alu_control, stall_count, out_regwrite);
    end
    rst_n = 1'b1;
    @(negedge clk);
    drive(2'b10, 6'h25, 32'h1, 32'h2, 32'h0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    checks++;
    if (out_valid !== 1'b1 || alu_control !== 4'b0001) begin
      failures++;
      $display("FAIL reset_preload: valid=%b ctl=%b want 1/0001", out_valid, alu_control);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0 || alu_control !== 4'b0000 || stall_count !== '0 || out_regwrite !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: valid=%b ctl=%b stall=%0d rw=%b want 0/0000/0/0", out_valid, alu_control, stall_count, out_regwrite);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_backpressure();
    exp_t e;
    @(negedge clk);
    drive(2'b00, 6'h00, 32'd10, 32'd99, 32'd4, 1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'b01, 6'h00, 32'd50, 32'd8, 32'd0, 1'b0, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_in_ready: got %b want 0", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || observed() !== sb[0]) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b got %h want %h", i, out_valid, observed(), sb[0]);
      end
    end
    checks++;
    if (stall_count !== 4'd4) begin
      failures++;
      $display("FAIL bp_stall_count: got %0d want 4", stall_count);
    end
    e = sb.pop_front();
    out_ready = 1'b1;
    sb.push_back(model(2'b01, 6'h00, 32'd50, 32'd8, 32'd0, 1'b0, 5'd7, 1'b1, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || observed() !== e) begin
      failures++;
      $display("FAIL bp_release: valid=%b got %h want %h", out_valid, observed(), e);
    end
    checks++;
    if (stall_count !== 4'd4) begin
      failures++;
      $display("FAIL bp_stall_after: got %0d want 4", stall_count);
    end
  endtask

  task automatic test_slt();
    exp_t e;
    @(negedge clk);
    drive(2'b10, 6'h2a, 32'd5, 32'd7, 32'd123, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || observed() !== e || alu_control !== 4'b0111 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      failures++;
      $display("FAIL slt: valid=%b got %h want %h", out_valid, observed(), e);
    end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    drive(2'b00, 6'h00, 32'h11, 32'h22, 32'h55, 1'b0, 5'd3, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    exm_regwrite = 1'b1; exm_dst = 5'd3; exm_data = 32'hAA;
    mwb_regwrite = 1'b1; mwb_dst = 5'd3; mwb_data = 32'hBB;
    #1;
    checks++;
    if (alu_a !== 32'hAA || alu_b !== 32'hAA || store_data !== 32'hAA) begin
      failures++;
      $display("FAIL fwd_exm_priority: a=%h b=%h sd=%h want aa/aa/aa", alu_a, alu_b, store_data);
    end
    exm_regwrite = 1'b0; #1;
    checks++;
    if (alu_a !== 32'hBB || alu_b !== 32'hBB) begin
      failures++;
      $display("FAIL fwd_mwb: a=%h b=%h want bb/bb", alu_a, alu_b);
    end
    exm_regwrite = 1'b1; exm_dst = 5'd0; mwb_dst = 5'd0; #1;
    checks++;
    if (alu_a !== 32'h11 || alu_b !== 32'h22) begin
      failures++;
      $display("FAIL fwd_dst0: a=%h b=%h want 11/22", alu_a, alu_b);
    end
    @(negedge clk);
    drive(2'b00, 6'h00, 32'h33, 32'h44, 32'h66, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; #1;
    checks++;
    if (alu_a !== 32'h33 || alu_b !== 32'h66 || store_data !== 32'h44) begin
      failures++;
      $display("FAIL fwd_reg0: a=%h b=%h sd=%h want 33/66/44", alu_a, alu_b, store_data);
    end
    exm_regwrite = 1'b0; mwb_regwrite = 1'b0; exm_data = '0; mwb_data = '0;
  endtask

  task automatic test_flush();
    exp_t e;
    @(negedge clk);
    drive(2'b00, 6'h00, 32'd1, 32'd2, 32'd3, 1'b0, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || observed() !== e || out_memread !== 1'b1) begin
      failures++;
      $display("FAIL flush_preload: valid=%b got %h want %h", out_valid, observed(), e);
    end
    out_ready = 1'b0; flush = 1'b1;
    drive(2'b01, 6'h00, 32'd9, 32'd9, 32'd9, 1'b0, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_regwrite !== 1'b0 || out_memwrite !== 1'b0 || out_memread !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear: valid=%b rw=%b mw=%b mr=%b want 0/0/0/0", out_valid, out_regwrite, out_memwrite, out_memread);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_dropped: valid=%b want 0", out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_illegal();
    exp_t e;
    @(negedge clk);
    drive(2'b10, 6'h00, 32'd4, 32'd6, 32'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || observed() !== e || out_illegal !== 1'b1 || alu_control !== 4'b0010 || out_regwrite !== 1'b0) begin
      failures++;
      $display("FAIL illegal: valid=%b got %h want %h", out_valid, observed(), e);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [1:0] ops[12] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00};
    logic [5:0] fns[12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h3f, 6'h2a, 6'h2a, 6'h00, 6'h20};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || observed() !== e) begin
          failures++;
          $display("FAIL b2b_%0d: valid=%b got %h want %h", i - 1, out_valid, observed(), e);
        end
      end
      drive(ops[i], fns[i], $urandom, $urandom, $urandom, 1'(i % 3 == 2),
            5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'(i + 1), 1'b1, 1'b0, 1'(i % 2), 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || observed() !== e) begin
      failures++;
      $display("FAIL b2b_11: valid=%b got %h want %h", out_valid, observed(), e);
    end
  endtask

  task automatic test_stall_saturate();
    @(negedge clk);
    rst_n = 1'b0; #1 rst_n = 1'b1;
    drive(2'b00, 6'h00, 32'd1, 32'd1, 32'd1, 1'b0, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (stall_count !== 4'hF) begin
      failures++;
      $display("FAIL stall_saturate: got %0d want 15", stall_count);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_count !== 4'hF || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold: stall=%0d valid=%b want 15/0", stall_count, out_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_backpressure();
    test_slt();
    test_forwarding();
    test_flush();
    test_illegal();
    test_back_to_back();
    test_stall_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
